// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The ERR state exists only when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 8;
  localparam int PC_INC  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
`ifdef FETCH_TIMEOUT_EN
    HOLD  = 2'd2,
    ERR   = 2'd3
`else
    HOLD  = 2'd2
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, word-aligned redirect load (priority), +4 increment.
// Arithmetic wraps modulo 2^ADDR_W. o_pc_next is the value the PC takes at the
// coming edge (ignoring reset), so the caller can track it in the same cycle.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc_next
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_unused_lsb;

  // The two low target bits are discarded by alignment.
  assign w_unused_lsb = ^i_load_pc[1:0];

  // Select the next PC: redirect beats increment, otherwise hold.
  always_comb begin
    w_pc_next = r_pc;
    if (i_load) begin
      w_pc_next = {i_load_pc[ADDR_W-1:2], 2'b00};
    end else if (i_inc) begin
      w_pc_next = r_pc + ADDR_W'(PC_INC);
    end else begin
      w_pc_next = r_pc;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc_next = w_pc_next;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: IDLE/FETCH/HOLD FSM over a req/ack instruction memory, an
// instruction register handed to decode via valid/ready, and the immediate
// slice feeding the sign extender. Optional fetch timeout: FETCH_TIMEOUT_EN.
// imem_addr comes from a request-address register so a redirect arriving
// while a request is outstanding never disturbs the address on the bus.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0,
  parameter int                IMM_LSB     = 0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [IMM_W-1:0]   imm_data,
  output logic               imm_sign,
  output logic               fetch_err
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic               r_flush;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_ack_fetch;
  logic               w_inc;
  logic               w_capture;

  // An ack in FETCH completes the request; data is kept only if not flushed or redirected.
  assign w_ack_fetch = (r_state == FETCH) && imem_ack;
  assign w_inc       = w_ack_fetch && !r_flush;
  assign w_capture   = w_ack_fetch && !r_flush && !redirect;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .i_load    (redirect),
    .i_load_pc (redirect_pc),
    .i_inc     (w_inc),
    .o_pc_next (w_pc_next)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_tcnt;

  // Count FETCH cycles without ack; cleared outside FETCH and on every ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if ((r_state == FETCH) && !imem_ack) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end else begin
      r_tcnt <= '0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; redirect takes priority over a consumed HOLD.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (fetch_en) begin
          w_state_next = FETCH;
        end else begin
          w_state_next = IDLE;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (r_flush || redirect) begin
            w_state_next = FETCH;
          end else begin
            w_state_next = HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
        end else if (r_tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_state_next = ERR;
`endif
        end else begin
          w_state_next = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_state_next = FETCH;
        end else if (instr_ready) begin
          w_state_next = fetch_en ? FETCH : IDLE;
        end else begin
          w_state_next = HOLD;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERR: begin
        w_state_next = ERR;
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Flush flag: a redirect while a request is outstanding marks its data stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush <= 1'b0;
    end else if (r_state == FETCH) begin
      if (imem_ack) begin
        r_flush <= 1'b0;
      end else if (redirect) begin
        r_flush <= 1'b1;
      end else begin
        r_flush <= r_flush;
      end
    end else begin
      r_flush <= 1'b0;
    end
  end

  // Request address follows the PC except while a request waits for its ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= RESET_PC;
    end else if ((r_state != FETCH) || imem_ack) begin
      r_addr <= w_pc_next;
    end else begin
      r_addr <= r_addr;
    end
  end

  // Instruction register and its fetch address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= imem_rdata;
      r_instr_pc <= r_addr;
    end else begin
      r_instr    <= r_instr;
      r_instr_pc <= r_instr_pc;
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_addr;
  assign instr_valid = (r_state == HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign imm_data    = r_instr[IMM_LSB +: IMM_W];
  assign imm_sign    = r_instr[IMM_LSB + IMM_W - 1];
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = (r_state == ERR);
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the timeout section depends on FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [7:0]  imm_data;
  logic        imm_sign;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .imm_data    (imm_data),
    .imm_sign    (imm_sign),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of the downstream sign extender.
  function automatic logic [31:0] sext(input logic [7:0] d, input logic s);
    return {{24{s}}, d};
  endfunction

  initial begin
    reset = 1'b1; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b1; imem_rdata = 32'h0; instr_ready = 1'b1;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imm", {23'd0, imm_sign, imm_data}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);

    // 1: back-to-back fetches with immediate ack
    reset = 1'b0; imem_rdata = 32'hA000_0001;
    tick();
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick();
    chk("t1_valid0", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr0", instr, 32'hA000_0001);
    chk("t1_ipc0", instr_pc, 32'h0);
    chk("t1_req_hold", {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'hA000_0002;
    tick();
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_req1", {31'd0, imem_req}, 32'd1);
    chk("t1_valid_gap", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t1_valid1", {31'd0, instr_valid}, 32'd1);
    chk("t1_ipc1", instr_pc, 32'h4);
    chk("t1_instr1", instr, 32'hA000_0002);
    tick();
    chk("t1_addr2", imem_addr, 32'h8);

    // 2: immediate slice held stable while decode stalls
    imem_rdata = 32'h0000_00F3; instr_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_ipc", instr_pc, 32'h8);
    chk("t2_imm", {24'd0, imm_data}, 32'h0000_00F3);
    chk("t2_sign", {31'd0, imm_sign}, 32'd1);
    chk("t2_ext", sext(imm_data, imm_sign), 32'hFFFF_FFF3);
    tick(); tick(); tick();
    chk("t2_valid_held", {31'd0, instr_valid}, 32'd1);
    chk("t2_imm_held", {23'd0, imm_sign, imm_data}, 32'h0000_01F3);
    chk("t2_req_held", {31'd0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    tick();
    chk("t2_req_next", {31'd0, imem_req}, 32'd1);
    chk("t2_addr_next", imem_addr, 32'hC);
    chk("t2_valid_drop", {31'd0, instr_valid}, 32'd0);

    // 3: redirect while FETCH waits; ack 3 cycles later is dropped
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("t3_addr_stable", imem_addr, 32'hC);
    chk("t3_req_stable", {31'd0, imem_req}, 32'd1);
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t3_addr_new", imem_addr, 32'h100);
    chk("t3_req_new", {31'd0, imem_req}, 32'd1);
    chk("t3_no_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h0000_0155;
    tick();
    imem_ack = 1'b0;
    chk("t3_valid", {31'd0, instr_valid}, 32'd1);
    chk("t3_instr", instr, 32'h0000_0155);
    chk("t3_ipc", instr_pc, 32'h100);

    // 4: redirect and valid&ready together
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("t4_valid0", {31'd0, instr_valid}, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    tick();
    chk("t4_no_dup", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr_held", imem_addr, 32'h200);

    // 5: redirect coinciding with ack, then wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    redirect = 1'b0;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t5_no_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("t5_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("t5_instr", instr, 32'h1234_5678);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    tick();
    chk("t5_wrap_req", {31'd0, imem_req}, 32'd1);
    chk("t5_wrap_addr2", imem_addr, 32'h0);

    // consume with fetch_en=0 -> IDLE; redirect in IDLE stays IDLE
    imem_ack = 1'b1; imem_rdata = 32'h0000_0080;
    tick();
    imem_ack = 1'b0; fetch_en = 1'b0;
    chk("idle_imm_sign", {31'd0, imm_sign}, 32'd1);
    chk("idle_ext", sext(imm_data, imm_sign), 32'hFFFF_FF80);
    tick();
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    tick();
    redirect = 1'b0;
    chk("idle_redir_req", {31'd0, imem_req}, 32'd0);
    chk("idle_redir_addr", imem_addr, 32'h40);
    fetch_en = 1'b1;
    tick();
    chk("idle_go_req", {31'd0, imem_req}, 32'd1);
    chk("idle_go_addr", imem_addr, 32'h40);

    // reset mid-FETCH drops the request; a late ack is ignored
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    chk("rstf_req", {31'd0, imem_req}, 32'd0);
    chk("rstf_addr", imem_addr, 32'h0);
    tick();
    chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
    chk("rstf_instr", instr, 32'h0);
    imem_ack = 1'b0;

    // 6: no ack ever
    fetch_en = 1'b1;
    tick();
    chk("t6_req0", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("t6_err_pre", {31'd0, fetch_err}, 32'd0);
    chk("t6_req_pre", {31'd0, imem_req}, 32'd1);
    tick();
    chk("t6_err", {31'd0, fetch_err}, 32'd1);
    chk("t6_req_off", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("t6_req_sticky", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_err_clr", {31'd0, fetch_err}, 32'd0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("t6_req_wait", {31'd0, imem_req}, 32'd1);
    chk("t6_addr_wait", imem_addr, 32'h0);
    chk("t6_err_tied", {31'd0, fetch_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
